histo_frame_seq: RTL

HISTO_FRAME_SEQ -- requirements
Module: histo_frame_seq

---
 rtl/histo_frame_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/histo_frame_seq.sv
// histo_frame_seq: arms on start, lets an external histogram accumulate one full sensor
// frame, then streams every bin count out over a valid/ready port.
// Optional build macro HISTO_SUM_WORD_EN appends a 24-bit sum word after the last bin.
module histo_frame_seq #(
    parameter int NUM_BINS = 1024,
    parameter int RD_LAT   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        frame_valid,
    output logic        histo_rw,
    output logic [9:0]  histo_bin,
    input  logic [23:0] histo_data,
    output logic [23:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic        overrun
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        CAPTURE,
        SETBIN,
        WAIT,
        PRESENT,
        DONE
    } state_t;

    localparam logic [9:0] LAST_BIN = 10'(NUM_BINS - 1);
    localparam logic [7:0] LAT_LOAD = 8'(RD_LAT - 1);

    state_t      state_reg;
    logic        fv_reg;
    logic [9:0]  index_reg;
    logic [7:0]  lat_reg;
    logic        histo_rw_reg;
    logic [9:0]  histo_bin_reg;
    logic [23:0] out_data_reg;
    logic        out_valid_reg;
    logic        out_last_reg;
    logic [15:0] frame_cnt_reg;
    logic        overrun_reg;
`ifdef HISTO_SUM_WORD_EN
    logic [23:0] sum_reg;
    logic        sum_phase_reg;
`endif

    logic fv_rise;
    logic fv_fall;
    logic in_readout;

    // Edges are taken against the registered copy so a frame already high at arm time is skipped.
    assign fv_rise    = frame_valid & ~fv_reg;
    assign fv_fall    = ~frame_valid & fv_reg;
    assign in_readout = (state_reg == SETBIN) || (state_reg == WAIT) || (state_reg == PRESENT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            fv_reg        <= 1'b0;
            index_reg     <= '0;
            lat_reg       <= '0;
            histo_rw_reg  <= 1'b0;
            histo_bin_reg <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            frame_cnt_reg <= '0;
            overrun_reg   <= 1'b0;
`ifdef HISTO_SUM_WORD_EN
            sum_reg       <= '0;
            sum_phase_reg <= 1'b0;
`endif
        end else begin
            fv_reg <= frame_valid;

            if (fv_rise && in_readout) begin
                overrun_reg <= 1'b1;
            end

            if (abort && (state_reg != IDLE)) begin
                state_reg     <= IDLE;
                histo_rw_reg  <= 1'b0;
                histo_bin_reg <= '0;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
`ifdef HISTO_SUM_WORD_EN
                sum_phase_reg <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        histo_rw_reg  <= 1'b0;
                        histo_bin_reg <= '0;
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        if (start && !abort) begin
                            state_reg <= ARM;
                        end
                    end
                    ARM: begin
                        if (fv_rise) begin
                            histo_rw_reg <= 1'b1;
                            state_reg    <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (fv_fall) begin
                            histo_rw_reg  <= 1'b0;
                            histo_bin_reg <= '0;
                            index_reg     <= '0;
                            state_reg     <= SETBIN;
`ifdef HISTO_SUM_WORD_EN
                            sum_reg       <= '0;
                            sum_phase_reg <= 1'b0;
`endif
                        end
                    end
                    SETBIN: begin
                        histo_bin_reg <= index_reg;
                        lat_reg       <= LAT_LOAD;
                        state_reg     <= WAIT;
                    end
                    WAIT: begin
                        if (lat_reg == 8'd0) begin
                            out_data_reg  <= histo_data;
                            out_valid_reg <= 1'b1;
`ifdef HISTO_SUM_WORD_EN
                            out_last_reg  <= 1'b0;
`else
                            out_last_reg  <= (index_reg == LAST_BIN);
`endif
                            state_reg     <= PRESENT;
                        end else begin
                            lat_reg <= lat_reg - 8'd1;
                        end
                    end
                    PRESENT: begin
                        if (out_ready) begin
`ifdef HISTO_SUM_WORD_EN
                            if (sum_phase_reg) begin
                                out_valid_reg <= 1'b0;
                                out_last_reg  <= 1'b0;
                                sum_phase_reg <= 1'b0;
                                state_reg     <= DONE;
                            end else if (index_reg == LAST_BIN) begin
                                // Last bin accepted: the sum word replaces it without dropping valid.
                                out_data_reg  <= sum_reg + out_data_reg;
                                out_last_reg  <= 1'b1;
                                sum_phase_reg <= 1'b1;
                            end else begin
                                sum_reg       <= sum_reg + out_data_reg;
                                out_valid_reg <= 1'b0;
                                index_reg     <= index_reg + 10'd1;
                                state_reg     <= SETBIN;
                            end
`else
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            if (index_reg == LAST_BIN) begin
                                state_reg <= DONE;
                            end else begin
                                index_reg <= index_reg + 10'd1;
                                state_reg <= SETBIN;
                            end
`endif
                        end
                    end
                    DONE: begin
                        frame_cnt_reg <= frame_cnt_reg + 16'd1;
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                        state_reg     <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign histo_rw  = histo_rw_reg;
    assign histo_bin = histo_bin_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign busy      = (state_reg != IDLE);
    assign frame_cnt = frame_cnt_reg;
    assign overrun   = overrun_reg;

endmodule
